// File: rtl/nibble_serial_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry slice per nibble, LSB first.
// Optional feature: define NSAS_SATURATE_EN to clamp the result on signed overflow.
module nibble_serial_add_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] yn_q;
    logic             sub_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CW+1:0]    lo_idx;
    logic [3:0]       xn;
    logic [3:0]       yn;
    logic [3:0]       lo3;
    logic [1:0]       hi;
    logic [3:0]       nib_sum;
    logic             c_out;
    logic             ovf;
    logic [WIDTH-1:0] raw_final;
    logic [WIDTH-1:0] final_sum;

    assign lo_idx = {cnt, 2'b00};
    assign xn     = x_q[lo_idx +: 4];
    assign yn     = yn_q[lo_idx +: 4];

    // Split the slice at bit 3 so the carry into the MSB is visible for overflow.
    assign lo3     = {1'b0, xn[2:0]} + {1'b0, yn[2:0]} + {3'b000, carry};
    assign hi      = {1'b0, xn[3]} + {1'b0, yn[3]} + {1'b0, lo3[3]};
    assign nib_sum = {hi[0], lo3[2:0]};
    assign c_out   = hi[1];
    assign ovf     = lo3[3] ^ hi[1];

    assign raw_final = {nib_sum, sum[WIDTH-5:0]};

`ifdef NSAS_SATURATE_EN
    assign final_sum = !ovf ? raw_final :
                       x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign final_sum = raw_final;
`endif

    assign in_ready = rst_n & (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            v         <= 1'b0;
            zero      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            x_q       <= '0;
            yn_q      <= '0;
            sub_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q   <= x;
                        yn_q  <= y ^ {WIDTH{sub}};
                        sub_q <= sub;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= c_out;
                    if (cnt == LAST) begin
                        sum       <= final_sum;
                        zero      <= (final_sum == '0);
                        v         <= ovf;
                        cout      <= c_out ^ sub_q;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        sum[lo_idx +: 4] <= nib_sum;
                        cnt              <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_sub.sv
// Directed self-checking bench for nibble_serial_add_sub at WIDTH=16.
module tb_nibble_serial_add_sub;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sub = 1'b0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             v;
    logic             zero;

    int errors = 0;
    int checks = 0;

    nibble_serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .cin       (cin),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .v         (v),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for IDLE, then presents one operation for exactly the accept edge.
    task automatic applyStimulus(input logic s, input logic c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("in_ready_before_op", 32'(in_ready), 32'd1);
        sub      = s;
        cin      = c;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag, output int edges);
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'd5);
    endtask

    task automatic runOp(input string tag, input logic s, input logic c,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] es, input logic ec, input logic ev, input logic ez);
        int edges;
        applyStimulus(s, c, a, b);
        waitDone(tag, edges);
        checkOutput({tag, "_sum"},  32'(sum),  32'(es));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(ec));
        checkOutput({tag, "_v"},    32'(v),    32'(ev));
        checkOutput({tag, "_zero"}, 32'(zero), 32'(ez));
        checkOutput({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        tick();
    endtask

    initial begin
        int edges;

        #2;
        checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum",       32'(sum),       32'd0);
        checkOutput("rst_flags",     32'({cout, v, zero}), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        runOp("add_ffff_1",  1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        runOp("sub_0_1",     1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        runOp("sub_5_3_b",   1'b1, 1'b1, 16'h0005, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0);
        runOp("add_mixed",   1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0, 1'b0);
`ifdef NSAS_SATURATE_EN
        runOp("add_ovf",     1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        runOp("sub_ovf",     1'b1, 1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
`else
        runOp("add_ovf",     1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        runOp("sub_ovf",     1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`endif

        // Back-pressure: hold the result in DONE while new operands are offered.
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h00F0, 16'h0F0F);
        waitDone("bp", edges);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x        = 16'hAAAA;
            y        = 16'h5555;
            tick();
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
            checkOutput("bp_sum",       32'(sum),       32'h0FFF);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(in_ready),  32'd1);
        checkOutput("bp_sum_held",      32'(sum),       32'h0FFF);
        runOp("after_bp", 1'b1, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0);

        // Reset during the third nibble of an operation.
        applyStimulus(1'b0, 1'b0, 16'h1111, 16'h2222);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_rst_sum",   32'(sum),       32'd0);
        checkOutput("midrun_rst_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrun_release_ready", 32'(in_ready), 32'd1);
        tick();
        runOp("after_rst", 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
